// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: 2-entry in-order FIFO of {result, destination, condition-pass}
// feeding the register file, plus the architectural {V,C,N,Z} flags register.
module alu_writeback_stage #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] alu_f,
    input  logic [3:0]    alu_status,
    input  logic [AW-1:0] rd_addr,
    input  logic          set_flags,
    input  logic [3:0]    cond,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_we,
    output logic [3:0]    flags
);

    logic [1:0]    count;
    logic          wr_ptr;
    logic          rd_ptr;
    logic [DW-1:0] mem_f    [2];
    logic [AW-1:0] mem_addr [2];
    logic          mem_pass [2];
    logic          push;
    logic          pop;

    // Condition evaluation against the entry's own status, {V,C,N,Z}.
    function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] st);
        logic v, c, n, z;
        v = st[3];
        c = st[2];
        n = st[1];
        z = st[0];
        case (cc)
            4'd0:    cond_eval = z;
            4'd1:    cond_eval = ~z;
            4'd2:    cond_eval = c;
            4'd3:    cond_eval = ~c;
            4'd4:    cond_eval = n;
            4'd5:    cond_eval = ~n;
            4'd6:    cond_eval = v;
            4'd7:    cond_eval = ~v;
            4'd8:    cond_eval = c & ~z;
            4'd9:    cond_eval = ~c | z;
            4'd10:   cond_eval = (n == v);
            4'd11:   cond_eval = (n != v);
            4'd12:   cond_eval = ~z & (n == v);
            4'd13:   cond_eval = z | (n != v);
            4'd14:   cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    // Handshake decoded from registered count only; no out_ready -> in_ready path.
    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_data = mem_f[rd_ptr];
    assign out_addr = mem_addr[rd_ptr];
    assign out_we   = out_valid & mem_pass[rd_ptr] & (mem_addr[rd_ptr] != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            flags  <= 4'b0000;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (push && set_flags) flags <= alu_status;
        end
    end

    // Payload storage is left unreset; count and pointers decide what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_f[wr_ptr]    <= alu_f;
            mem_addr[wr_ptr] <= rd_addr;
            mem_pass[wr_ptr] <= cond_eval(cond, alu_status);
        end
    end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Bench for alu_writeback_stage: directed scenarios then random traffic, all
// checked against a queue-based reference model.
module tb_alu_writeback_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] alu_f;
    logic [3:0]    alu_status;
    logic [AW-1:0] rd_addr;
    logic          set_flags;
    logic [3:0]    cond;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_we;
    logic [3:0]    flags;

    alu_writeback_stage #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_f      (alu_f),
        .alu_status (alu_status),
        .rd_addr    (rd_addr),
        .set_flags  (set_flags),
        .cond       (cond),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_we     (out_we),
        .flags      (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] f;
        logic [AW-1:0] a;
        logic          p;
    } ent_t;

    ent_t          mq[$];
    logic [3:0]    mflags;
    logic [DW-1:0] popped[$];
    int            checks = 0;
    int            errors = 0;

    // Condition codes come in complementary pairs: evaluate the even member, flip for odd.
    function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] s);
        logic v, cy, n, z, b;
        v = s[3]; cy = s[2]; n = s[1]; z = s[0];
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cy;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cy && !z;
            3'd5: b = (n == v);
            3'd6: b = !z && (n == v);
            default: b = 1'b1;
        endcase
        return b ^ c[0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check outputs against the model, clock once, advance the model.
    task automatic step();
        logic exp_ready, exp_valid, do_push, do_pop;
        ent_t e;
        exp_ready = (mq.size() < 2);
        exp_valid = (mq.size() != 0);
        chk("in_ready", in_ready, exp_ready);
        chk("out_valid", out_valid, exp_valid);
        chk("flags", flags, mflags);
        if (exp_valid) begin
            chk("out_data", out_data, mq[0].f);
            chk("out_addr", out_addr, mq[0].a);
            chk("out_we", out_we, mq[0].p && (mq[0].a != 0));
        end
        do_push = rst_n && in_valid && exp_ready;
        do_pop  = rst_n && exp_valid && out_ready;
        if (do_pop) popped.push_back(out_data);
        e.f = alu_f;
        e.a = rd_addr;
        e.p = ref_pass(cond, alu_status);
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            mflags = 4'b0000;
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back(e);
                if (set_flags) mflags = alu_status;
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] f, input logic [AW-1:0] a,
                         input logic [3:0] st, input logic [3:0] c, input logic sf);
        in_valid = v; alu_f = f; rd_addr = a; alu_status = st; cond = c; set_flags = sf;
    endtask

    initial begin
        rst_n = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, '0, '0, 4'h0, 4'hE, 1'b0);
        mflags = 4'b0000;
        @(posedge clk);
        #1;
        step();

        // Reset state
        rst_n = 1'b1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_we", out_we, 1'b0);
        chk("rst_flags", flags, 4'b0000);

        // Single push, one-cycle latency
        out_ready = 1'b1;
        drive(1'b1, 32'h5, 5'd3, 4'h0, 4'd14, 1'b0);
        step();
        drive(1'b0, '0, '0, 4'h0, 4'hE, 1'b0);
        chk("lat_valid", out_valid, 1'b1);
        chk("lat_data", out_data, 32'h5);
        chk("lat_addr", out_addr, 5'd3);
        chk("lat_we", out_we, 1'b1);
        step();
        chk("lat_drain", out_valid, 1'b0);

        // Back-pressure: three pushes with out_ready low, C held
        out_ready = 1'b0;
        popped.delete();
        drive(1'b1, 32'hA, 5'd1, 4'h0, 4'd14, 1'b0); step();
        drive(1'b1, 32'hB, 5'd2, 4'h0, 4'd14, 1'b0); step();
        chk("bp_full", in_ready, 1'b0);
        drive(1'b1, 32'hC, 5'd3, 4'h0, 4'd14, 1'b0); step();
        step();
        chk("bp_hold", in_ready, 1'b0);
        out_ready = 1'b1;
        step();
        step();
        drive(1'b0, '0, '0, 4'h0, 4'hE, 1'b0);
        step();
        step();
        chk("bp_count", popped.size(), 3);
        if (popped.size() == 3) begin
            chk("bp_order0", popped[0], 32'hA);
            chk("bp_order1", popped[1], 32'hB);
            chk("bp_order2", popped[2], 32'hC);
        end

        // Conditional write enable
        drive(1'b1, 32'h11, 5'd7, 4'b0001, 4'd1, 1'b0); step();
        chk("ne_we", out_we, 1'b0);
        drive(1'b1, 32'h12, 5'd7, 4'b0001, 4'd0, 1'b0); step();
        chk("eq_we", out_we, 1'b1);
        drive(1'b1, 32'h13, 5'd0, 4'b0000, 4'd14, 1'b0); step();
        chk("r0_we", out_we, 1'b0);
        drive(1'b0, '0, '0, 4'h0, 4'hE, 1'b0); step();

        // Flags update only with set_flags
        drive(1'b1, 32'h21, 5'd4, 4'b1010, 4'd15, 1'b1); step();
        drive(1'b1, 32'h22, 5'd4, 4'b0001, 4'd14, 1'b0); step();
        drive(1'b0, '0, '0, 4'h0, 4'hE, 1'b0);
        chk("flags_keep", flags, 4'b1010);
        drive(1'b1, 32'h23, 5'd4, 4'b0100, 4'd14, 1'b1); step();
        drive(1'b0, '0, '0, 4'h0, 4'hE, 1'b0);
        chk("flags_load", flags, 4'b0100);
        step(); step();

        // Simultaneous push/pop at count=1, then reset with two entries
        out_ready = 1'b0;
        drive(1'b1, 32'h31, 5'd5, 4'h0, 4'd14, 1'b0); step();
        out_ready = 1'b1;
        drive(1'b1, 32'h32, 5'd6, 4'h0, 4'd14, 1'b0); step();
        chk("pp_valid", out_valid, 1'b1);
        chk("pp_ready", in_ready, 1'b1);
        chk("pp_head", out_data, 32'h32);
        out_ready = 1'b0;
        drive(1'b1, 32'h33, 5'd6, 4'h0, 4'd14, 1'b1); step();
        chk("pp_full", in_ready, 1'b0);
        rst_n = 1'b0;
        out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        drive(1'b0, '0, '0, 4'h0, 4'hE, 1'b0);
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_flags", flags, 4'b0000);
        chk("mid_rst_ready", in_ready, 1'b1);
        step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            out_ready = $urandom_range(0, 2) != 0;
            drive($urandom_range(0, 2) != 0, $urandom, AW'($urandom_range(0, 7)),
                  4'($urandom), 4'($urandom), $urandom_range(0, 1) != 0);
            step();
        end
        rst_n = 1'b1;
        drive(1'b0, '0, '0, 4'h0, 4'hE, 1'b0);
        out_ready = 1'b1;
        step(); step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
